// File: rtl/aes_pkg.sv
// Shared AES constants, FSM encoding and parameter legality check for the
// iterative SubBytes engine.
package aes_pkg;

  localparam int AES_BLOCK_BITS = 128;
  localparam int AES_BYTE_BITS  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fsm_state_t;

  function automatic bit bpc_legal(input int bpc);
    return (bpc == 1) || (bpc == 2) || (bpc == 4) || (bpc == 8) || (bpc == 16);
  endfunction

endpackage

// File: rtl/sub_byte_iter_if.sv
// Input/output valid-ready handshake bundle for sub_byte_iter; keys are
// big-endian byte order, byte k at bits [8k:8k+7].
interface sub_byte_iter_if;
  import aes_pkg::*;

  logic                      in_valid;
  logic                      in_ready;
  logic [0:AES_BLOCK_BITS-1] in_key;
  logic                      out_valid;
  logic                      out_ready;
  logic [0:AES_BLOCK_BITS-1] out_key;

  modport master (
    output in_valid, in_key, out_ready,
    input  in_ready, out_valid, out_key
  );

  modport slave (
    input  in_valid, in_key, out_ready,
    output in_ready, out_valid, out_key
  );

endinterface

// File: rtl/inv_sbox.sv
// Combinational inverse FIPS-197 S-box; only built with SUB_BYTE_INV_EN.
`ifdef SUB_BYTE_INV_EN
module inv_sbox (
  input  logic [3:0] hi,
  input  logic [3:0] lo,
  output logic [7:0] sub
);

  localparam logic [2047:0] TABLE = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  assign sub = TABLE[11'(2047 - 8 * int'({hi, lo})) -: 8];

endmodule
`endif

// File: rtl/sbox.sv
// Combinational forward FIPS-197 S-box, addressed by high/low nibble.
module sbox (
  input  logic [3:0] hi,
  input  logic [3:0] lo,
  output logic [7:0] sub
);

  // Entry n sits at bits [2047-8n -: 8]; rows below are table rows 0x0..0xf.
  localparam logic [2047:0] TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign sub = TABLE[11'(2047 - 8 * int'({hi, lo})) -: 8];

endmodule

// File: rtl/sub_byte_iter.sv
// Iterative AES SubBytes: BYTES_PER_CYCLE bytes per clock through a shared S-box bank.
// Optional SUB_BYTE_INV_EN adds an inv input selecting InvSubBytes per block.
module sub_byte_iter
  import aes_pkg::*;
#(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic clk,
  input  logic rst_n,
`ifdef SUB_BYTE_INV_EN
  input  logic inv,
`endif
  sub_byte_iter_if.slave bus
);

  localparam int NUM_STEPS = 16 / BYTES_PER_CYCLE;
  localparam int CNT_W     = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_STEPS - 1);

  if (!bpc_legal(BYTES_PER_CYCLE)) begin : g_bad_bpc
    $error("sub_byte_iter: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  fsm_state_t                state;
  logic [CNT_W-1:0]          cnt;
  logic [0:AES_BLOCK_BITS-1] data_p0;
  logic [0:AES_BLOCK_BITS-1] nxt_data;
  logic                      vld_p0;
  logic                      armed;
  logic                      accept;

  logic [AES_BYTE_BITS-1:0] sub_in  [BYTES_PER_CYCLE];
  logic [AES_BYTE_BITS-1:0] fwd_out [BYTES_PER_CYCLE];
  logic [AES_BYTE_BITS-1:0] sub_res [BYTES_PER_CYCLE];

  // armed keeps in_ready low for the first cycle out of reset.
  assign bus.in_ready  = armed & ((state == IDLE) | ((state == DONE) & bus.out_ready));
  assign bus.out_valid = vld_p0;
  assign bus.out_key   = data_p0;
  assign accept        = bus.in_valid & bus.in_ready;

  always_comb begin
    for (int g = 0; g < BYTES_PER_CYCLE; g++) begin
      sub_in[g] = data_p0[7'(8 * (int'(cnt) * BYTES_PER_CYCLE + g)) +: 8];
    end
  end

`ifdef SUB_BYTE_INV_EN
  logic                     inv_q;
  logic [AES_BYTE_BITS-1:0] inv_out [BYTES_PER_CYCLE];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      inv_q <= 1'b0;
    else if (accept) inv_q <= inv;
  end
`endif

  for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_sbox
    sbox u_sbox (.hi(sub_in[g][7:4]), .lo(sub_in[g][3:0]), .sub(fwd_out[g]));
`ifdef SUB_BYTE_INV_EN
    inv_sbox u_inv_sbox (.hi(sub_in[g][7:4]), .lo(sub_in[g][3:0]), .sub(inv_out[g]));
    assign sub_res[g] = inv_q ? inv_out[g] : fwd_out[g];
`else
    assign sub_res[g] = fwd_out[g];
`endif
  end

  // Stage p0 write-back: only the current group changes, the rest hold.
  always_comb begin
    nxt_data = data_p0;
    for (int g = 0; g < BYTES_PER_CYCLE; g++) begin
      nxt_data[7'(8 * (int'(cnt) * BYTES_PER_CYCLE + g)) +: 8] = sub_res[g];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      data_p0 <= '0;
      vld_p0  <= 1'b0;
      armed   <= 1'b0;
    end else begin
      armed <= 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            data_p0 <= bus.in_key;
            cnt     <= '0;
            state   <= BUSY;
          end
        end
        BUSY: begin
          data_p0 <= nxt_data;
          if (cnt == LAST_CNT) begin
            state  <= DONE;
            vld_p0 <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            vld_p0 <= 1'b0;
            if (accept) begin
              data_p0 <= bus.in_key;
              cnt     <= '0;
              state   <= BUSY;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sub_byte_iter.sv
// Directed bench for sub_byte_iter: reset, single block, backpressure, streaming,
// mid-block reset, BYTES_PER_CYCLE sweep and (with SUB_BYTE_INV_EN) inverse mode.
module tb_sub_byte_iter;

  localparam logic [127:0] K1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] R1 = 128'h638293c31bfc33f5c4eeacea4bc12816;

  logic clk = 1'b0;
  logic rst_n;
  logic inv;
  int   checks = 0;
  int   errors = 0;
  int   lat;
  bit   busy_rdy;

  always #5 clk = ~clk;

  sub_byte_iter_if bus ();

  sub_byte_iter #(.BYTES_PER_CYCLE(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef SUB_BYTE_INV_EN
    .inv   (inv),
`endif
    .bus   (bus)
  );

  // Sweep instances share one stimulus source.
  localparam int SW_BPC [4] = '{1, 2, 8, 16};
  localparam int SW_LAT [4] = '{16, 8, 2, 1};
  logic         sw_valid;
  logic         sw_ready;
  logic [127:0] sw_key;
  logic         sw_ov  [4];
  logic [127:0] sw_out [4];

  for (genvar k = 0; k < 4; k++) begin : g_sw
    sub_byte_iter_if sif ();
    assign sif.in_valid  = sw_valid;
    assign sif.in_key    = sw_key;
    assign sif.out_ready = sw_ready;
    assign sw_ov[k]      = sif.out_valid;
    assign sw_out[k]     = sif.out_key;
    sub_byte_iter #(.BYTES_PER_CYCLE(SW_BPC[k])) u_sw (
      .clk   (clk),
      .rst_n (rst_n),
`ifdef SUB_BYTE_INV_EN
      .inv   (inv),
`endif
      .bus   (sif)
    );
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges from the accepting edge until out_valid; 0 means timeout.
  task automatic wait_out(output int l);
    l = 0;
    busy_rdy = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      tick();
      if (bus.out_valid) begin
        l = e;
        break;
      end
      if (bus.in_ready) busy_rdy = 1'b1;
    end
  endtask

  int           sw_lat [4];
  logic [127:0] sw_res [4];

  initial begin
    rst_n         = 1'b0;
    inv           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_key    = '0;
    bus.out_ready = 1'b0;
    sw_valid      = 1'b0;
    sw_ready      = 1'b0;
    sw_key        = '0;
    repeat (2) tick();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_key", bus.out_key, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    rst_n = 1'b1;
    tick();
    chk("ready_after_rst", bus.in_ready, 1);

    // Single block
    bus.in_key = K1; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.in_key   = '1;
    chk("busy_in_ready", bus.in_ready, 0);
    wait_out(lat);
    chk("single_latency", lat, 4);
    chk("single_busy_ready", busy_rdy, 0);
    chk("single_key", bus.out_key, R1);
    tick();
    chk("single_valid_drop", bus.out_valid, 0);
    chk("single_idle_ready", bus.in_ready, 1);

    // Backpressure
    bus.out_ready = 1'b0; bus.in_key = '0; bus.in_valid = 1'b1;
    tick();
    bus.in_key = '1;
    wait_out(lat);
    chk("bp_latency", lat, 4);
    chk("bp_key", bus.out_key, {16{8'h63}});
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("bp_hold_valid", bus.out_valid, 1);
      chk("bp_hold_key", bus.out_key, {16{8'h63}});
      chk("bp_hold_ready", bus.in_ready, 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk("bp_release_valid", bus.out_valid, 0);
    chk("bp_release_ready", bus.in_ready, 1);
    tick();
    chk("bp_idle_valid", bus.out_valid, 0);

    // Streaming: second block accepted on the first block's transfer edge
    bus.in_key = {16{8'h53}}; bus.in_valid = 1'b1;
    tick();
    bus.in_key = {16{8'hff}};
    wait_out(lat);
    chk("stream1_latency", lat, 4);
    chk("stream1_key", bus.out_key, {16{8'hed}});
    chk("stream_done_ready", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    chk("stream_reload_valid", bus.out_valid, 0);
    chk("stream_reload_busy", bus.in_ready, 0);
    wait_out(lat);
    chk("stream2_latency", lat, 4);
    chk("stream2_key", bus.out_key, {16{8'h16}});
    tick();

    // Reset two cycles into BUSY
    bus.in_key = K1; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", bus.out_valid, 0);
    chk("midrst_key", bus.out_key, 0);
    chk("midrst_ready", bus.in_ready, 0);
    tick();
    rst_n = 1'b1;
    tick();
    bus.in_key = {16{8'h01}}; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    wait_out(lat);
    chk("after_rst_latency", lat, 4);
    chk("after_rst_key", bus.out_key, {16{8'h7c}});
    tick();

    // Parameter sweep
    sw_key = K1; sw_ready = 1'b1; sw_valid = 1'b1;
    tick();
    sw_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sw_lat[k] = 0;
      sw_res[k] = '0;
    end
    for (int e = 1; e <= 20; e++) begin
      tick();
      for (int k = 0; k < 4; k++) begin
        if (sw_ov[k] && sw_lat[k] == 0) begin
          sw_lat[k] = e;
          sw_res[k] = sw_out[k];
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("sweep%0d_latency", SW_BPC[k]), sw_lat[k], SW_LAT[k]);
      chk($sformatf("sweep%0d_key", SW_BPC[k]), sw_res[k], R1);
    end

`ifdef SUB_BYTE_INV_EN
    // Inverse mode; inv is captured at acceptance only
    inv = 1'b1; bus.in_key = R1; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    inv = 1'b0;
    wait_out(lat);
    chk("inv_latency", lat, 4);
    chk("inv_key", bus.out_key, K1);
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
